// File: rtl/ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx : PS/2 device-to-host serial receiver
//
// Synchronises and deglitches the raw PS/2 clock and data lines, then
// deserialises 11-bit frames (start 0, 8 data bits LSB first, odd parity,
// stop 1). Each good byte is presented with a one-cycle strobe. Bad frames
// (parity, stop or inter-edge timeout) give a one-cycle error strobe and the
// receiver returns to IDLE ready for the very next start bit.
//
// Ports
//   CLOCK_50          in   1  system clock, all state on posedge
//   reset             in   1  asynchronous active-low reset (0 = reset)
//   PS2_CLK           in   1  raw PS/2 clock (open collector, idle high)
//   PS2_DAT           in   1  raw PS/2 data
//   received_data     out  8  last correctly received byte
//   received_data_en  out  1  one-cycle strobe: received_data just updated
//   frame_error       out  1  one-cycle strobe: frame discarded
//   busy              out  1  high while a frame is in progress
//
// Strobe semantics: received_data_en and frame_error are single-cycle
// pulses with no back-pressure; they are mutually exclusive, and
// received_data is valid in the same cycle received_data_en is high and
// holds its value until the next good frame.
// -----------------------------------------------------------------------------
module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       frame_error,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers (reset to the idle-high line level)
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   dat;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat   = dat_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Clock deglitch filter
  // filt_cnt counts consecutive synced samples that disagree with clk_f.
  // Once FILTER_LEN such samples have been seen, clk_f toggles on the next
  // edge; any agreeing sample in between restarts the count.
  // ---------------------------------------------------------------------------
  logic          clk_f;
  logic          clk_f_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      clk_f    <= 1'b1;
      clk_f_d  <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_f_d <= clk_f;
      if (filt_cnt == FW'(FILTER_LEN)) begin
        clk_f    <= ~clk_f;
        filt_cnt <= '0;
      end else if (clk_s != clk_f) begin
        filt_cnt <= filt_cnt + 1'b1;
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // High for exactly the one cycle after clk_f went 1->0.
  assign fall = clk_f_d & ~clk_f;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t        state_q;
  state_t        state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    data_q;
  logic          par_q;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          good_d;
  logic          err_d;

  assign timeout = (state_q != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES));

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Timeout takes priority over a coincident fall so a
  // stalled frame can never complete on a late edge.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!dat) state_d = DATA;   // dat=1 here is a false start
        DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: strobe requests (registered below) and busy.
  always_comb begin
    good_d = 1'b0;
    err_d  = 1'b0;
    if (timeout) begin
      err_d = 1'b1;
    end else if (fall && (state_q == STOP)) begin
      // Odd parity over data+parity, and the stop bit must be 1.
      if (((^data_q) ^ par_q) && dat) good_d = 1'b1;
      else                            err_d  = 1'b1;
    end
  end

  assign busy = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Datapath: bit counter, shift register, parity latch, timeout counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
    end else if (fall && !timeout) begin
      case (state_q)
        IDLE: bit_cnt <= '0;
        DATA: begin
          data_q[bit_cnt] <= dat;
          bit_cnt         <= bit_cnt + 3'd1;
        end
        PARITY:  par_q <= dat;
        default: ;
      endcase
    end
  end

  // Held at zero in IDLE and cleared on every fall; a timeout returns the
  // FSM to IDLE, so the counter never runs past TIMEOUT_CYCLES.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
    end else if ((state_q == IDLE) || fall || timeout) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Registered strobes and received byte.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      received_data    <= '0;
      received_data_en <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      received_data_en <= good_d;
      frame_error      <= err_d;
      if (good_d) received_data <= data_q;
    end
  end

endmodule
